// File: rtl/e203_rr_arb8_ctrl.sv
// ---------------------------------------------------------------------------
// e203_rr_arb8_ctrl
//   8-requester round-robin burst arbiter in front of one shared downstream
//   port. The winning requester owns the port for a whole multi-beat burst.
//   A burst ends on the owner's last beat, or when the beat limit forces a
//   release. Priority then rotates to the requester after the owner.
//
// Parameters
//   MAX_BEATS : forced-release beat limit per burst (0 = unlimited)
//   CNT_W     : beat counter width, must hold MAX_BEATS
//
// Ports
//   clk       : clock, all state on the rising edge
//   rst       : synchronous active-high reset
//   req_i     : per-requester request, held by the owner for the whole burst
//   last_i    : per-requester last-beat flag (only the owner's bit is used)
//   gnt_o     : registered one-hot grant, zero when there is no owner
//   gnt_idx_o : registered binary index of the owner, zero when no owner
//   gnt_vld_o : beat valid to downstream (owner present and still requesting)
//   gnt_rdy_i : downstream beat accept
//   busy_o    : registered, high while a burst owns the port
//
// Build option
//   E203_RR_ARB8_BACK2BACK_EN : when defined, a releasing burst hands the
//   port straight to the next waiting requester on the same edge (no idle
//   bubble). When undefined, every release spends one cycle in IDLE.
// ---------------------------------------------------------------------------
module e203_rr_arb8_ctrl #(
   parameter int unsigned MAX_BEATS = 16,
   parameter int unsigned CNT_W     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req_i,
   input  logic [7:0] last_i,
   output logic [7:0] gnt_o,
   output logic [2:0] gnt_idx_o,
   output logic       gnt_vld_o,
   input  logic       gnt_rdy_i,
   output logic       busy_o
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT_M1 = (MAX_BEATS == 0) ? {CNT_W{1'b0}}
                                                            : CNT_W'(MAX_BEATS - 1);
   localparam logic             LIMIT_EN = (MAX_BEATS != 0);

   // Round-robin search: scanning offsets from high to low means the lowest
   // offset from ptr (the highest-priority requester) is the final assignment.
   // Result is {found, index}.
   function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'd1 << idx;
   endfunction

   state_t           state_r;
   logic [2:0]       ptr_r;
   logic [CNT_W-1:0] beat_cnt_r;
   logic [7:0]       gnt_r;
   logic [2:0]       gnt_idx_r;
   logic             busy_r;

   logic             vld_s;
   logic             hs_s;
   logic             limit_s;
   logic             release_s;
   logic [2:0]       next_ptr_s;
   logic [3:0]       idle_pick_s;
`ifdef E203_RR_ARB8_BACK2BACK_EN
   logic [3:0]       b2b_pick_s;
`endif

   // Beat handshake, release decision and arbitration candidates.
   always_comb begin
      vld_s       = (state_r == ST_OWN) & req_i[gnt_idx_r];
      hs_s        = vld_s & gnt_rdy_i;
      limit_s     = LIMIT_EN & (beat_cnt_r == LIMIT_M1);
      release_s   = hs_s & (last_i[gnt_idx_r] | limit_s);
      next_ptr_s  = gnt_idx_r + 3'd1;
      idle_pick_s = rr_pick(req_i, ptr_r);
`ifdef E203_RR_ARB8_BACK2BACK_EN
      // The releasing owner is masked out so it cannot immediately re-win.
      b2b_pick_s  = rr_pick(req_i & ~onehot8(gnt_idx_r), next_ptr_s);
`endif
   end

   assign gnt_vld_o = vld_s;
   assign gnt_o     = gnt_r;
   assign gnt_idx_o = gnt_idx_r;
   assign busy_o    = busy_r;

   // Ownership state machine with registered grant outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         ptr_r      <= 3'd0;
         beat_cnt_r <= {CNT_W{1'b0}};
         gnt_r      <= 8'd0;
         gnt_idx_r  <= 3'd0;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (idle_pick_s[3]) begin
                  state_r    <= ST_OWN;
                  gnt_r      <= onehot8(idle_pick_s[2:0]);
                  gnt_idx_r  <= idle_pick_s[2:0];
                  busy_r     <= 1'b1;
                  beat_cnt_r <= {CNT_W{1'b0}};
               end
            end
            ST_OWN: begin
               if (release_s) begin
                  ptr_r      <= next_ptr_s;
                  beat_cnt_r <= {CNT_W{1'b0}};
`ifdef E203_RR_ARB8_BACK2BACK_EN
                  if (b2b_pick_s[3]) begin
                     state_r   <= ST_OWN;
                     gnt_r     <= onehot8(b2b_pick_s[2:0]);
                     gnt_idx_r <= b2b_pick_s[2:0];
                     busy_r    <= 1'b1;
                  end else begin
                     state_r   <= ST_IDLE;
                     gnt_r     <= 8'd0;
                     gnt_idx_r <= 3'd0;
                     busy_r    <= 1'b0;
                  end
`else
                  state_r   <= ST_IDLE;
                  gnt_r     <= 8'd0;
                  gnt_idx_r <= 3'd0;
                  busy_r    <= 1'b0;
`endif
               end else if (hs_s) begin
                  // Saturate instead of wrapping (only reachable when unlimited).
                  if (beat_cnt_r != CNT_MAX) begin
                     beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               gnt_r      <= 8'd0;
               gnt_idx_r  <= 3'd0;
               busy_r     <= 1'b0;
               beat_cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_e203_rr_arb8_ctrl.sv
module tb_e203_rr_arb8_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'd0;
   logic [7:0] last = 8'd0;
   logic       rdy = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       busy;

   // Second instance with unlimited bursts and a narrow saturating counter.
   logic [7:0] u_req = 8'd0;
   logic [7:0] u_last = 8'd0;
   logic       u_rdy = 1'b0;
   logic [7:0] u_gnt;
   logic [2:0] u_gnt_idx;
   logic       u_vld;
   logic       u_busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_gnt;

   always #5 clk = ~clk;

   e203_rr_arb8_ctrl #(.MAX_BEATS(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .req_i(req), .last_i(last), .gnt_o(gnt),
      .gnt_idx_o(gnt_idx), .gnt_vld_o(gnt_vld), .gnt_rdy_i(rdy), .busy_o(busy));

   e203_rr_arb8_ctrl #(.MAX_BEATS(0), .CNT_W(2)) dut_u (
      .clk(clk), .rst(rst), .req_i(u_req), .last_i(u_last), .gnt_o(u_gnt),
      .gnt_idx_o(u_gnt_idx), .gnt_vld_o(u_vld), .gnt_rdy_i(u_rdy), .busy_o(u_busy));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'd0; step(); step();
      rst = 1'b0;
      n_checks++; if (gnt !== 8'h00) begin n_errors++; $display("FAIL reset_gnt got=%h want=00", gnt); end
      n_checks++; if (gnt_idx !== 3'd0) begin n_errors++; $display("FAIL reset_idx got=%0d want=0", gnt_idx); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_checks++; if (gnt_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld got=%b want=0", gnt_vld); end
   endtask

   // Grant 0 first, then after release 7 beats 0 (rotation, not fixed priority).
   task automatic test_round_robin();
      req = 8'h81; last = 8'h01; rdy = 1'b0; step();
      n_checks++; if (gnt !== 8'h01) begin n_errors++; $display("FAIL rr_gnt0 got=%h want=01", gnt); end
      n_checks++; if (gnt_idx !== 3'd0) begin n_errors++; $display("FAIL rr_idx0 got=%0d want=0", gnt_idx); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rr_busy0 got=%b want=1", busy); end
      n_checks++; if (gnt_vld !== 1'b1) begin n_errors++; $display("FAIL rr_vld0 got=%b want=1", gnt_vld); end
      req = 8'h01; rdy = 1'b1; step();
      n_checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin n_errors++; $display("FAIL rr_release gnt=%h busy=%b want 00/0", gnt, busy); end
      req = 8'h81; last = 8'h00; rdy = 1'b0; step();
      n_checks++; if (gnt !== 8'h80) begin n_errors++; $display("FAIL rr_gnt7 got=%h want=80", gnt); end
      n_checks++; if (gnt_idx !== 3'd7) begin n_errors++; $display("FAIL rr_idx7 got=%0d want=7", gnt_idx); end
   endtask

   // Pointer wraps 7 -> 0, then advances past owner 0 to requester 3.
   task automatic test_wrap();
      req = 8'h80; last = 8'h80; rdy = 1'b1; step();
      n_checks++; if (gnt !== 8'h00) begin n_errors++; $display("FAIL wrap_rel7 got=%h want=00", gnt); end
      req = 8'h09; last = 8'h00; rdy = 1'b0; step();
      n_checks++; if (gnt !== 8'h01) begin n_errors++; $display("FAIL wrap_gnt0 got=%h want=01", gnt); end
      req = 8'h01; last = 8'h01; rdy = 1'b1; step();
      req = 8'h09; last = 8'h00; rdy = 1'b0; step();
      n_checks++; if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin n_errors++; $display("FAIL wrap_gnt3 got=%h/%0d want=08/3", gnt, gnt_idx); end
      req = 8'h08; last = 8'h08; rdy = 1'b1; step();
   endtask

   // Backpressure must not count beats; the limit of 4 exposes any extra count.
   task automatic test_backpressure();
      logic [7:0] pat [3];
      pat[0] = 8'hFF; pat[1] = 8'h34; pat[2] = 8'hFD;
      req = 8'h04; last = 8'h00; rdy = 1'b0; step();
      n_checks++; if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin n_errors++; $display("FAIL bp_gnt got=%h/%0d want=04/2", gnt, gnt_idx); end
      for (int i = 0; i < 3; i++) begin
         req = pat[i]; step();
         n_checks++; if (gnt !== 8'h04 || busy !== 1'b1) begin n_errors++; $display("FAIL bp_stall%0d gnt=%h busy=%b want 04/1", i, gnt, busy); end
      end
      req = 8'h04; last = 8'hFB; rdy = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h04);
      exp_q.push_back(8'h00);
      while (exp_q.size() > 0) begin
         step();
         exp_gnt = exp_q.pop_front();
         n_checks++; if (gnt !== exp_gnt) begin n_errors++; $display("FAIL bp_beat gnt=%h want=%h", gnt, exp_gnt); end
      end
      last = 8'h00; rdy = 1'b0;
   endtask

   // Limit release after 4 handshakes, with an owner request drop in between.
   task automatic test_limit();
      req = 8'h20; rdy = 1'b1; step();
      n_checks++; if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin n_errors++; $display("FAIL lim_gnt got=%h/%0d want=20/5", gnt, gnt_idx); end
      step(); step();
      req = 8'h00; #1;
      n_checks++; if (gnt_vld !== 1'b0) begin n_errors++; $display("FAIL lim_drop_vld got=%b want=0", gnt_vld); end
      step(); step();
      n_checks++; if (busy !== 1'b1 || gnt !== 8'h20) begin n_errors++; $display("FAIL lim_drop_hold busy=%b gnt=%h want 1/20", busy, gnt); end
      req = 8'h20; step();
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL lim_beat3 busy=%b want=1", busy); end
      step();
      n_checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin n_errors++; $display("FAIL lim_release gnt=%h busy=%b want 00/0", gnt, busy); end
      req = 8'h61; rdy = 1'b0; step();
      n_checks++; if (gnt !== 8'h40) begin n_errors++; $display("FAIL lim_ptr6 got=%h want=40", gnt); end
      req = 8'h40; last = 8'h40; rdy = 1'b1; step();
      last = 8'h00; rdy = 1'b0;
   endtask

   // Reset mid-burst drops ownership and returns the pointer to 0.
   task automatic test_reset_mid_burst();
      req = 8'h08; rdy = 1'b0; step();
      n_checks++; if (gnt !== 8'h08) begin n_errors++; $display("FAIL rmb_gnt got=%h want=08", gnt); end
      rdy = 1'b1; step(); step();
      rst = 1'b1; last = 8'h08; step();
      rst = 1'b0; last = 8'h00; rdy = 1'b0;
      n_checks++; if (gnt !== 8'h00 || gnt_idx !== 3'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL rmb_after gnt=%h idx=%0d busy=%b want 00/0/0", gnt, gnt_idx, busy); end
      req = 8'h88; step();
      n_checks++; if (gnt !== 8'h08) begin n_errors++; $display("FAIL rmb_regrant got=%h want=08", gnt); end
      req = 8'h08; last = 8'h08; rdy = 1'b1; step();
      last = 8'h00; rdy = 1'b0; req = 8'h00;
   endtask

   // Constant two-way contention with single-beat bursts.
   task automatic test_back_to_back();
      req = 8'h03; last = 8'h03; rdy = 1'b1;
`ifdef E203_RR_ARB8_BACK2BACK_EN
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
`else
      exp_q.push_back(8'h01); exp_q.push_back(8'h00);
      exp_q.push_back(8'h02); exp_q.push_back(8'h00);
      exp_q.push_back(8'h01); exp_q.push_back(8'h00);
      exp_q.push_back(8'h02);
`endif
      while (exp_q.size() > 0) begin
         step();
         exp_gnt = exp_q.pop_front();
         n_checks++; if (gnt !== exp_gnt) begin n_errors++; $display("FAIL b2b_seq gnt=%h want=%h", gnt, exp_gnt); end
      end
      req = 8'h00; last = 8'h00; rdy = 1'b0;
   endtask

   // Unlimited bursts: counter saturates, only last_i releases.
   task automatic test_unlimited();
      u_req = 8'h01; u_last = 8'h00; u_rdy = 1'b1; step();
      n_checks++; if (u_gnt !== 8'h01) begin n_errors++; $display("FAIL unl_gnt got=%h want=01", u_gnt); end
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++; if (u_busy !== 1'b1 || u_gnt !== 8'h01) begin n_errors++; $display("FAIL unl_beat%0d busy=%b gnt=%h want 1/01", i, u_busy, u_gnt); end
      end
      u_last = 8'h01; step();
      n_checks++; if (u_busy !== 1'b0 || u_gnt !== 8'h00) begin n_errors++; $display("FAIL unl_release busy=%b gnt=%h want 0/00", u_busy, u_gnt); end
      u_req = 8'h00; u_last = 8'h00; u_rdy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_limit();
      test_reset_mid_burst();
      test_back_to_back();
      test_unlimited();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
